demux_stream_1ton: RTL and testbench
====================================

// Module: demux_stream_1ton
// PURPOSE
//  Parametrised 1-to-N packet demultiplexer with valid/ready handshake, packet-locked routing and one register stage.
//  Steers a single input stream to one of N_OUT output channels.
//  Selection is sampled on the first beat of each packet and held until the last beat.
//  Sits between a shared ingress stream and per-channel consumers, e.g. lab datapath fan-out.
// PARAMETERS
//  DATA_W  8  data width per beat
//  N_OUT   8  number of output channels, N_OUT >= 2
//  SEL_W   3  select width; must satisfy 2**SEL_W >= N_OUT
// PORTS
//  clk      in   1             single clock, rising edge
//  rst_n    in   1             asynchronous, active-low reset
//  s_valid  in   1             input beat valid
//  s_ready  out  1             input beat accepted when s_valid & s_ready
//  s_data   in   DATA_W        input beat data
//  s_sel    in   SEL_W         destination channel; sampled on first beat of a packet only
//  s_last   in   1             last beat of packet
//  m_valid  out  N_OUT         one-hot (or zero) per-channel valid
//  m_ready  in   N_OUT         per-channel ready
//  m_data   out  DATA_W        registered data, shared by all channels
//  m_last   out  1             registered last flag, shared by all channels
//  busy     out  1             1 while a packet is open (state != IDLE) or the output reg is full
// BEHAVIOUR
//  Reset values
//  - Reset asserted asynchronously; all outputs clear immediately: m_valid=0, m_data=0, m_last=0, state=IDLE, dest=0.
//  - Mid-packet reset discards the open packet and the held beat; no partial state survives.
//  Output register
//  - One entry: out_vld, out_dst, m_data, m_last.
//  - m_valid = out_vld ? (1 << out_dst) : 0.
//  - Entry retires on m_ready[out_dst] while out_vld.
//  - s_ready = !out_vld | m_ready[out_dst], or 1 in state DROP.
//  - Latency: accepted beat appears on m_* the next cycle.
//  - Full throughput: 1 beat/clk while the destination stays ready.
//  - Retire and load in the same cycle is legal; the new beat replaces the old one.
//  - Head-of-line blocking is by design: a stalled channel stalls the input.
//  FSM
//  - IDLE: on an accepted beat, route by s_sel.
//    - s_sel < N_OUT: load the reg with out_dst = s_sel and latch dest = s_sel. If !s_last go to ROUTE, else stay IDLE.
//    - s_sel >= N_OUT: discard the beat and count one drop. If !s_last go to DROP, else stay IDLE.
//  - ROUTE: s_sel is ignored. Accepted beats load the reg with out_dst = dest. On an accepted s_last go to IDLE.
//  - DROP: s_ready = 1 and the reg is untouched. Beats are consumed silently; on an accepted s_last go to IDLE.
//  Boundary cases
//  - Single-beat packet (s_last on first beat): stays IDLE, so the next beat's s_sel is re-sampled.
//  - A packet to a new channel while the reg holds a beat for another channel waits until that beat retires.
//  - m_valid is never multi-hot.
// CONFIGURATION
//  DEMUX_DROP_CNT_EN
//  - Defined: adds output port drop_cnt [15:0].
//    - Reset 0.
//    - +1 per dropped packet, counted on its first beat.
//    - Saturates at 16'hFFFF.
//  - Undefined: no port, no counter. Dropping behaviour is otherwise identical.
// STRUCTURE
//  Shared package demux_pkg.vh holds:
//  - FSM encodings: ST_IDLE=2'd0, ST_ROUTE=2'd1, ST_DROP=2'd2.
//  - DROP_CNT_W=16.
//  One sub-module: demux_out_reg, the single-entry register slice (data/last/dst/vld with load and retire).
//  FSM and select decode stay in the top.
// TESTING
//  1. Reset: assert rst_n=0 mid-packet -> m_valid=0 immediately, busy=0. After release the first beat is treated as a new packet.
//  2. Routing: 3-beat packet with s_sel=5, all m_ready=1 -> m_valid=8'h20 for 3 cycles starting 1 clk after the first accept; m_last on the 3rd.
//  3. Lock: s_sel changes to 2 on beats 2-3 of a packet started with sel=5 -> all beats go to ch5.
//  4. Back-pressure: m_ready[5]=0 for 4 clks -> s_ready=0 and m_data held stable. Release -> the next beat is loaded the same cycle.
//  5. Drop: N_OUT=6, s_sel=7 on a 4-beat packet -> s_ready=1 for all beats, m_valid stays 0, drop_cnt 0->1 (with DEMUX_DROP_CNT_EN).
//  6. Back-to-back 1-beat packets sel=0,1,2 with all ready -> m_valid=1,2,4 on consecutive cycles, no bubbles.

Source files
------------

// File: rtl/demux_stream_1ton_pkg.sv
// Shared types and constants for the 1-to-N packet demultiplexer.
package demux_stream_1ton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the demultiplexer: one shared ingress plus N per-channel egress lanes.
interface demux_stream_1ton_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [SEL_W-1:0]  s_sel;
  logic              s_last;
  logic [N_OUT-1:0]  m_valid;
  logic [N_OUT-1:0]  m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, s_sel, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_sel, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/demux_stream_1ton_out_reg.sv
// Single-entry output slice: holds one beat with its destination; load wins over retire.
module demux_stream_1ton_out_reg #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [SEL_W-1:0]  ld_dst,
  input  logic              retire,
  output logic              vld,
  output logic [SEL_W-1:0]  dst,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dst  <= '0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      dst  <= ld_dst;
      data <= ld_data;
      last <= ld_last;
    end else if (retire) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// 1-to-N packet demux: routes each packet by the select seen on its first beat.
// Define DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_stream_1ton
  import demux_stream_1ton_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_stream_1ton_if.slave    bus,
  output logic                  busy
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   dest;
  logic [SEL_W-1:0]   ld_dst;
  logic [SEL_W-1:0]   out_dst;
  logic               out_vld;
  logic               out_rdy;
  logic               accept;
  logic               sel_ok;
  logic               load;

  assign out_rdy      = bus.m_ready[out_dst];
  assign bus.s_ready  = (state == ST_DROP) || !out_vld || out_rdy;
  assign accept       = bus.s_valid && bus.s_ready;
  assign sel_ok       = 32'(bus.s_sel) < N_OUT;
  assign bus.m_valid  = out_vld ? (N_OUT'(1) << out_dst) : '0;
  assign busy         = (state != ST_IDLE) || out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dest  <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == ST_IDLE && sel_ok)
        dest <= bus.s_sel;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && !bus.s_last) state_nxt = sel_ok ? ST_ROUTE : ST_DROP;
      ST_ROUTE: if (accept && bus.s_last)  state_nxt = ST_IDLE;
      ST_DROP:  if (accept && bus.s_last)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Only the first beat looks at s_sel; later beats follow the latched destination.
  always_comb begin
    load   = 1'b0;
    ld_dst = dest;
    case (state)
      ST_IDLE: begin
        load   = accept && sel_ok;
        ld_dst = bus.s_sel;
      end
      ST_ROUTE: load = accept;
      default:  load = 1'b0;
    endcase
  end

  demux_stream_1ton_out_reg #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (bus.s_data),
    .ld_last (bus.s_last),
    .ld_dst  (ld_dst),
    .retire  (out_vld && out_rdy),
    .vld     (out_vld),
    .dst     (out_dst),
    .data    (bus.m_data),
    .last    (bus.m_last)
  );

`ifdef DEMUX_DROP_CNT_EN
  logic drop_start;

  assign drop_start = accept && (state == ST_IDLE) && !sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop_start && drop_cnt != {DROP_CNT_W{1'b1}})
      drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench for demux_stream_1ton: directed scenarios plus random traffic vs a packet-level scoreboard.
module tb_demux_stream_1ton;

  localparam int DW = 8;
  localparam int NO = 6;
  localparam int SW = 3;

  typedef struct {
    int           ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  beat_t exp_q[$];
  bit    pkt_open = 1'b0;
  bit    pkt_drop = 1'b0;
  int    pkt_dst = 0;
  int    exp_drops = 0;

  demux_stream_1ton_if #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) bus ();

  demux_stream_1ton #(
    .DATA_W (DW),
    .N_OUT  (NO),
    .SEL_W  (SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs are checked against the scoreboard before the next rising edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] sel,
                               input logic last, input logic [NO-1:0] rdy);
    beat_t         b;
    logic          retiring;
    logic          exp_srdy;
    logic [NO-1:0] mv;
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_sel   = sel;
    bus.s_last  = last;
    bus.m_ready = rdy;
    #1;
    mv = bus.m_valid;
    checkOutput("m_valid_present", 32'(mv != '0), 32'(exp_q.size() != 0));
    checkOutput("m_valid_onehot", 32'($countones(mv) <= 1), 32'd1);
    retiring = 1'b0;
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      checkOutput("m_valid_chan", 32'(mv), 32'(NO'(1) << b.ch));
      checkOutput("m_data", 32'(bus.m_data), 32'(b.data));
      checkOutput("m_last", 32'(bus.m_last), 32'(b.last));
      retiring = rdy[b.ch];
    end
    exp_srdy = pkt_drop || (exp_q.size() == 0) || retiring;
    checkOutput("s_ready", 32'(bus.s_ready), 32'(exp_srdy));
    checkOutput("busy", 32'(busy), 32'(pkt_open || exp_q.size() != 0));
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif
    if (retiring)
      void'(exp_q.pop_front());
    if (v && exp_srdy) begin
      if (!pkt_open) begin
        pkt_open = 1'b1;
        if (int'(sel) < NO) begin
          pkt_dst  = int'(sel);
          pkt_drop = 1'b0;
        end else begin
          pkt_drop = 1'b1;
          if (exp_drops < 65535)
            exp_drops++;
        end
      end
      if (!pkt_drop)
        exp_q.push_back('{pkt_dst, d, last});
      if (last) begin
        pkt_open = 1'b0;
        pkt_drop = 1'b0;
      end
    end
  endtask

  // Asynchronous reset in the middle of a low clock phase; outputs must clear before any edge.
  task automatic applyReset();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_m_last", 32'(bus.m_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
`ifdef DEMUX_DROP_CNT_EN
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    exp_q.delete();
    pkt_open  = 1'b0;
    pkt_drop  = 1'b0;
    exp_drops = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  localparam logic [NO-1:0] ALL_RDY = '1;
  localparam logic [NO-1:0] CH5_STALL = 6'b011111;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_sel   = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = ALL_RDY;
    applyReset();

    // Three-beat packet to channel 5; later selects must be ignored.
    applyStimulus(1'b1, 8'h11, 3'd5, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h12, 3'd2, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h13, 3'd2, 1'b1, ALL_RDY);
    repeat (2) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, ALL_RDY);

    // Channel 5 stalls for four cycles, then releases.
    applyStimulus(1'b1, 8'h21, 3'd5, 1'b0, CH5_STALL);
    repeat (4) applyStimulus(1'b1, 8'h22, 3'd1, 1'b0, CH5_STALL);
    applyStimulus(1'b1, 8'h22, 3'd1, 1'b1, ALL_RDY);
    repeat (2) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, ALL_RDY);

    // Out-of-range select drops a four-beat packet.
    applyStimulus(1'b1, 8'h31, 3'd7, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h32, 3'd1, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h33, 3'd3, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h34, 3'd0, 1'b1, ALL_RDY);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, ALL_RDY);

    // Back-to-back single-beat packets re-sample the select each beat.
    applyStimulus(1'b1, 8'h41, 3'd0, 1'b1, ALL_RDY);
    applyStimulus(1'b1, 8'h42, 3'd1, 1'b1, ALL_RDY);
    applyStimulus(1'b1, 8'h43, 3'd2, 1'b1, ALL_RDY);
    repeat (2) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, ALL_RDY);

    // Reset in the middle of a packet, then a fresh packet.
    applyStimulus(1'b1, 8'h51, 3'd4, 1'b0, ALL_RDY);
    applyStimulus(1'b1, 8'h52, 3'd4, 1'b0, ALL_RDY);
    applyReset();
    applyStimulus(1'b1, 8'h61, 3'd1, 1'b1, ALL_RDY);
    repeat (2) applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, ALL_RDY);

    // Random traffic with occasional back-pressure and dropped packets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    DW'($urandom),
                    SW'($urandom_range(0, 7)),
                    $urandom_range(0, 3) == 0,
                    NO'($urandom) | NO'($urandom));
    end
    repeat (3) applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, ALL_RDY);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
